// File: rtl/icache_pkg.sv
// Shared definitions for the instruction cache: the controller state encoding
// and the instruction word returned on a miss.
package icache_pkg;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_REQ  = 2'd1,
      ST_WAIT = 2'd2
   } icache_state_t;

   // addi x0, x0, 0 -- a harmless bubble for the fetch stage
   localparam logic [31:0] NOOP_INST = 32'h0000_0013;

endpackage

// File: rtl/icache_mem.sv
// Direct-mapped line storage: tag/data arrays with one combinational read
// port and one synchronous write port, plus a valid vector cleared on reset.
module icache_mem #(
   parameter int NUM_LINES = 32,
   parameter int IDX_BITS  = $clog2(NUM_LINES),
   parameter int TAG_BITS  = 32 - IDX_BITS - 2
) (
   input  logic                clk,
   input  logic                rst,
   input  logic [IDX_BITS-1:0] rd_idx,
   output logic [TAG_BITS-1:0] rd_tag,
   output logic [31:0]         rd_data,
   output logic                rd_valid,
   input  logic                wr_en,
   input  logic [IDX_BITS-1:0] wr_idx,
   input  logic [TAG_BITS-1:0] wr_tag,
   input  logic [31:0]         wr_data
);

   logic [TAG_BITS-1:0]  tag_mem  [NUM_LINES];
   logic [31:0]          data_mem [NUM_LINES];
   logic [NUM_LINES-1:0] valid_q;

   // Only the valid bits need a defined reset value; stale tags/data are masked.
   always_ff @(posedge clk) begin
      if (rst) begin
         valid_q <= '0;
      end else if (wr_en) begin
         valid_q[wr_idx] <= 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (wr_en) begin
         tag_mem[wr_idx]  <= wr_tag;
         data_mem[wr_idx] <= wr_data;
      end
   end

   assign rd_tag   = tag_mem[rd_idx];
   assign rd_data  = data_mem[rd_idx];
   assign rd_valid = valid_q[rd_idx];

endmodule

// File: rtl/icache.sv
// Blocking direct-mapped instruction cache with one-word lines and a single
// outstanding miss to backing memory.
module icache
   import icache_pkg::*;
#(
   parameter int NUM_LINES = 32,
   parameter int IDX_BITS  = $clog2(NUM_LINES)
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [31:0] proc2Imem_addr,
   output logic [31:0] Imem2proc_data,
   output logic        Imem2proc_valid,
   output logic        icache2mem_req,
   output logic [31:0] icache2mem_addr,
   input  logic        mem2icache_ack,
   input  logic        mem2icache_valid,
   input  logic [31:0] mem2icache_data
);

   localparam int TAG_BITS = 32 - IDX_BITS - 2;

   icache_state_t       state_q, state_d;
   logic [31:0]         miss_addr_q, miss_addr_d;
   logic                fill_en;
   logic                hit;

   logic [IDX_BITS-1:0] cur_idx;
   logic [TAG_BITS-1:0] cur_tag;
   logic [IDX_BITS-1:0] fill_idx;
   logic [TAG_BITS-1:0] fill_tag;
   logic [TAG_BITS-1:0] line_tag;
   logic [31:0]         line_data;
   logic                line_valid;

   assign cur_idx  = proc2Imem_addr[IDX_BITS+1:2];
   assign cur_tag  = proc2Imem_addr[31:IDX_BITS+2];
   assign fill_idx = miss_addr_q[IDX_BITS+1:2];
   assign fill_tag = miss_addr_q[31:IDX_BITS+2];

   icache_mem #(
      .NUM_LINES (NUM_LINES),
      .IDX_BITS  (IDX_BITS),
      .TAG_BITS  (TAG_BITS)
   ) u_mem (
      .clk      (clk),
      .rst      (rst),
      .rd_idx   (cur_idx),
      .rd_tag   (line_tag),
      .rd_data  (line_data),
      .rd_valid (line_valid),
      .wr_en    (fill_en),
      .wr_idx   (fill_idx),
      .wr_tag   (fill_tag),
      .wr_data  (mem2icache_data)
   );

   // Hits only count while idle; a pending fill hides even a matching line.
   assign hit = (state_q == ST_IDLE) && !rst && line_valid && (line_tag == cur_tag);

   assign Imem2proc_valid = hit;
   assign Imem2proc_data  = hit ? line_data : NOOP_INST;
   assign icache2mem_req  = (state_q == ST_REQ);
   assign icache2mem_addr = miss_addr_q;

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= ST_IDLE;
         miss_addr_q <= '0;
      end else begin
         state_q     <= state_d;
         miss_addr_q <= miss_addr_d;
      end
   end

   always_comb begin
      state_d     = state_q;
      miss_addr_d = miss_addr_q;
      fill_en     = 1'b0;
      unique case (state_q)
         ST_IDLE: begin
            if (!hit) begin
               miss_addr_d = proc2Imem_addr & ~32'h3;
               state_d     = ST_REQ;
            end
         end
         ST_REQ: begin
            // Ack and data arriving together complete the fill in one step.
            if (mem2icache_valid) begin
               fill_en = 1'b1;
               state_d = ST_IDLE;
            end else if (mem2icache_ack) begin
               state_d = ST_WAIT;
            end
         end
         ST_WAIT: begin
            if (mem2icache_valid) begin
               fill_en = 1'b1;
               state_d = ST_IDLE;
            end
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

endmodule

// File: tb/tb_icache.sv
// Directed bench for icache: cold miss, hit, conflict, slow memory, branch
// redirect during a fill, and reset while a fill is outstanding.
module tb_icache;
   import icache_pkg::*;

   logic        clk = 1'b0;
   logic        rst;
   logic [31:0] proc2Imem_addr;
   logic [31:0] Imem2proc_data;
   logic        Imem2proc_valid;
   logic        icache2mem_req;
   logic [31:0] icache2mem_addr;
   logic        mem2icache_ack;
   logic        mem2icache_valid;
   logic [31:0] mem2icache_data;

   int n_checks = 0;
   int n_errors = 0;

   icache #(.NUM_LINES(32)) dut (
      .clk              (clk),
      .rst              (rst),
      .proc2Imem_addr   (proc2Imem_addr),
      .Imem2proc_data   (Imem2proc_data),
      .Imem2proc_valid  (Imem2proc_valid),
      .icache2mem_req   (icache2mem_req),
      .icache2mem_addr  (icache2mem_addr),
      .mem2icache_ack   (mem2icache_ack),
      .mem2icache_valid (mem2icache_valid),
      .mem2icache_data  (mem2icache_data)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
      end
   endtask

   // Advance past the next rising edge; inputs change and outputs are sampled here.
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic mem_idle();
      mem2icache_ack   = 1'b0;
      mem2icache_valid = 1'b0;
      mem2icache_data  = 32'h0;
   endtask

   task automatic fill_now(input logic [31:0] data);
      mem2icache_ack   = 1'b1;
      mem2icache_valid = 1'b1;
      mem2icache_data  = data;
      tick();
      mem_idle();
      #1;
   endtask

   initial begin
      rst            = 1'b1;
      proc2Imem_addr = 32'h0;
      mem_idle();
      tick();
      tick();

      // reset state
      check("rst_valid", {31'b0, Imem2proc_valid}, 32'h0);
      check("rst_data",  Imem2proc_data, NOOP_INST);
      check("rst_req",   {31'b0, icache2mem_req}, 32'h0);
      check("rst_maddr", icache2mem_addr, 32'h0);

      // cold miss on 0x40
      proc2Imem_addr = 32'h0000_0040;
      rst            = 1'b0;
      #1;
      check("cold_miss_valid", {31'b0, Imem2proc_valid}, 32'h0);
      tick();
      check("cold_req",   {31'b0, icache2mem_req}, 32'h1);
      check("cold_maddr", icache2mem_addr, 32'h0000_0040);
      check("cold_req_valid", {31'b0, Imem2proc_valid}, 32'h0);
      fill_now(32'h0010_0093);
      check("cold_fill_valid", {31'b0, Imem2proc_valid}, 32'h1);
      check("cold_fill_data",  Imem2proc_data, 32'h0010_0093);
      check("cold_fill_req",   {31'b0, icache2mem_req}, 32'h0);

      // repeated hit
      tick();
      check("hit_valid", {31'b0, Imem2proc_valid}, 32'h1);
      check("hit_data",  Imem2proc_data, 32'h0010_0093);
      check("hit_req",   {31'b0, icache2mem_req}, 32'h0);

      // conflict: 0xC0 shares index 16 with 0x40
      proc2Imem_addr = 32'h0000_00C0;
      #1;
      check("conf_miss", {31'b0, Imem2proc_valid}, 32'h0);
      tick();
      check("conf_req",   {31'b0, icache2mem_req}, 32'h1);
      check("conf_maddr", icache2mem_addr, 32'h0000_00C0);
      fill_now(32'h0000_0013);
      check("conf_fill_valid", {31'b0, Imem2proc_valid}, 32'h1);
      check("conf_fill_data",  Imem2proc_data, 32'h0000_0013);
      proc2Imem_addr = 32'h0000_0040;
      #1;
      check("conf_evicted", {31'b0, Imem2proc_valid}, 32'h0);
      tick();

      // slow memory: cycle 1 is the first REQ cycle, ack on 3, data on 7
      for (int c = 1; c <= 7; c++) begin
         mem2icache_ack   = (c == 3);
         mem2icache_valid = (c == 7);
         mem2icache_data  = (c == 7) ? 32'h0010_0093 : 32'hFFFF_FFFF;
         #1;
         check($sformatf("slow_req_c%0d", c), {31'b0, icache2mem_req}, (c <= 3) ? 32'h1 : 32'h0);
         check($sformatf("slow_maddr_c%0d", c), icache2mem_addr, 32'h0000_0040);
         check($sformatf("slow_valid_c%0d", c), {31'b0, Imem2proc_valid}, 32'h0);
         tick();
      end
      mem_idle();
      #1;
      check("slow_fill_valid", {31'b0, Imem2proc_valid}, 32'h1);
      check("slow_fill_data",  Imem2proc_data, 32'h0010_0093);

      // redirect: evict 0x40, re-miss it, then move the fetch to 0x100 in WAIT
      proc2Imem_addr = 32'h0000_00C0;
      tick();
      fill_now(32'h0000_0013);
      proc2Imem_addr = 32'h0000_0040;
      tick();
      mem2icache_ack = 1'b1;
      tick();
      mem_idle();
      proc2Imem_addr = 32'h0000_0100;
      #1;
      check("redir_wait_req",   {31'b0, icache2mem_req}, 32'h0);
      check("redir_wait_valid", {31'b0, Imem2proc_valid}, 32'h0);
      mem2icache_valid = 1'b1;
      mem2icache_data  = 32'h0020_0093;
      tick();
      mem_idle();
      #1;
      check("redir_new_miss", {31'b0, Imem2proc_valid}, 32'h0);
      tick();
      check("redir_req",   {31'b0, icache2mem_req}, 32'h1);
      check("redir_maddr", icache2mem_addr, 32'h0000_0100);
      fill_now(32'h0030_0093);
      check("redir_100_data", Imem2proc_data, 32'h0030_0093);
      proc2Imem_addr = 32'h0000_0040;
      #1;
      check("redir_40_valid", {31'b0, Imem2proc_valid}, 32'h1);
      check("redir_40_data",  Imem2proc_data, 32'h0020_0093);

      // reset while waiting for 0xC0, then a stray fill beat
      proc2Imem_addr = 32'h0000_00C0;
      tick();
      mem2icache_ack = 1'b1;
      tick();
      mem_idle();
      rst = 1'b1;
      tick();
      rst              = 1'b0;
      proc2Imem_addr   = 32'h0000_0040;
      mem2icache_valid = 1'b1;
      mem2icache_data  = 32'hDEAD_BEEF;
      #1;
      check("rstw_req",   {31'b0, icache2mem_req}, 32'h0);
      check("rstw_maddr", icache2mem_addr, 32'h0);
      check("rstw_miss",  {31'b0, Imem2proc_valid}, 32'h0);
      tick();
      mem_idle();
      #1;
      check("rstw_req40",   {31'b0, icache2mem_req}, 32'h1);
      check("rstw_maddr40", icache2mem_addr, 32'h0000_0040);
      fill_now(32'h0040_0093);
      check("rstw_40_data", Imem2proc_data, 32'h0040_0093);
      proc2Imem_addr = 32'h0000_0000;
      #1;
      check("rstw_no_stray", {31'b0, Imem2proc_valid}, 32'h0);
      check("rstw_noop",     Imem2proc_data, NOOP_INST);
      tick();
      fill_now(32'h0050_0093);
      proc2Imem_addr = 32'h0000_0100;
      #1;
      check("rstw_100_cleared", {31'b0, Imem2proc_valid}, 32'h0);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

   initial begin
      #100000;
      $display("FAIL timeout: got running expected finished");
      $fatal(1, "timeout");
   end

endmodule

// File: doc/icache.md
ICACHE -- requirements
Module: icache

Interface
REQ-001 SHALL have parameter NUM_LINES, default 32, number of direct-mapped one-word lines (power of two, 2..256).
REQ-002 SHALL have parameter IDX_BITS, default $clog2(NUM_LINES), index width.
REQ-003 SHALL have port clk  input  1  system clock; single clock domain.
REQ-004 SHALL have port rst  input  1  synchronous, active-high reset.
REQ-005 SHALL have port proc2Imem_addr  input  32  fetch address from fetch stage; bits [1:0] ignored.
REQ-006 SHALL have port Imem2proc_data  output  32  fetched instruction.
REQ-007 SHALL have port Imem2proc_valid  output  1  Imem2proc_data is valid this cycle.
REQ-008 SHALL have port icache2mem_req  output  1  miss request to backing memory.
REQ-009 SHALL have port icache2mem_addr  output  32  word-aligned miss address.
REQ-010 SHALL have port mem2icache_ack  input  1  backing memory accepted request.
REQ-011 SHALL have port mem2icache_valid  input  1  fill data present.
REQ-012 SHALL have port mem2icache_data  input  32  fill word.

Function
REQ-013 SHALL decode index = addr[IDX_BITS+1:2], tag = addr[31:IDX_BITS+2].
REQ-014 SHALL flag a hit when state is IDLE, line valid, stored tag equals tag; hit is combinational, zero-cycle latency.
REQ-015 SHALL drive Imem2proc_valid=1 and Imem2proc_data=stored word on hit; otherwise valid=0 and data=NOOP_INST.
REQ-016 SHALL implement states IDLE, REQ, WAIT.
REQ-017 SHALL, in IDLE on miss, latch {addr[31:2],2'b00} into miss register and go to REQ next cycle.
REQ-018 SHALL, in REQ, hold icache2mem_req=1 and icache2mem_addr=miss register stable until mem2icache_ack=1.
REQ-019 SHALL, in REQ with ack=1 and valid=0, go to WAIT; req deasserts next cycle.
REQ-020 SHALL, in REQ or WAIT with mem2icache_valid=1, write data and tag at miss index, set valid bit, go to IDLE.
REQ-021 SHALL treat ack and valid in same REQ cycle as complete fill (REQ->IDLE).
REQ-022 SHALL complete an outstanding fill even if proc2Imem_addr changes (branch redirect); lookup resumes with current address in IDLE.
REQ-023 SHALL report miss (valid=0) during REQ/WAIT even if current address would hit; filled word appears via hit path the cycle after fill.
REQ-024 SHALL ignore mem2icache_valid and mem2icache_ack in IDLE.
REQ-025 SHALL drive icache2mem_req=0 outside REQ; icache2mem_addr equals miss register at all times.
REQ-026 SHALL replace existing line on fill (no replacement policy beyond direct mapping).

Reset
REQ-027 SHALL, on rst, clear all valid bits, state=IDLE, miss register=0, icache2mem_req=0, Imem2proc_valid=0, Imem2proc_data=NOOP_INST.
REQ-028 SHALL abandon an in-flight miss on rst; later fill data discarded per REQ-024.
REQ-029 SHALL NOT require data/tag arrays reset.

Structure
REQ-030 SHALL place NOOP_INST in shared sys_defs.vh; state enum icache_state_t in shared package.
REQ-031 SHALL instantiate one sub-module icache_mem holding tag/data/valid arrays (one combinational read, one synchronous write, sync valid clear).

Verification
REQ-032 SHALL test cold miss: addr 0x0000_0040 after reset -> req=1 addr 0x40 next cycle; ack+valid data 0x0010_0093 -> valid=1 data 0x0010_0093 cycle after.
REQ-033 SHALL test hit: repeat 0x40 -> valid=1 same cycle, req stays 0.
REQ-034 SHALL test conflict: 0xC0 (same index, NUM_LINES=32) -> miss, fill 0x0000_0013; then 0x40 misses again.
REQ-035 SHALL test delayed memory: ack at cycle 3, valid at cycle 7 -> req held 3 cycles, addr stable, valid=0 throughout, fill at 7.
REQ-036 SHALL test redirect: address changes to 0x100 during WAIT -> 0x40 line filled, then miss issued for 0x100.
REQ-037 SHALL test reset mid-WAIT, then valid=1 with stray data -> no line written, req=0, 0x40 still misses.
